// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared FFT constants plus log2 and bit-reverse helpers
package fft_reorder_pkg;
  localparam int DEF_N = 128;
  localparam int DEF_WIDTH = 16;
  function automatic int log2(int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [15:0] bitrev(logic [15:0] v, int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i < bits) r[4'(i)] = v[4'(bits - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, one write port and one synchronous read port
module fft_reorder_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong buffer turning bit-reversed FFT output into natural bin order
module fft_reorder import fft_reorder_pkg::*; #(
  parameter int N = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 di_en,
  input  logic [WIDTH-1:0]     di_re,
  input  logic [WIDTH-1:0]     di_im,
  output logic                 do_en,
  output logic [WIDTH-1:0]     do_re,
  output logic [WIDTH-1:0]     do_im,
  output logic [log2(N)-1:0]   do_idx
);
  localparam int AW = log2(N);
  logic [AW-1:0] wcnt, rcnt, ridx, wadr;
  logic wbank, rbank, active, rvalid;
  logic [1:0] full;
  logic we, rd_issue, wlast, rlast;
  logic [2*WIDTH-1:0] rdata;
  always_comb begin
    we = di_en && !full[wbank];
    rd_issue = active || full[rbank];
    wlast = we && (&wcnt);
    rlast = rd_issue && (&rcnt);
    wadr = AW'(bitrev(16'(wcnt), AW));
  end
  // Issue is combinational so bin 0 reaches do_en two edges after the frame completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      wbank <= 1'b0;
      full <= '0;
      rcnt <= '0;
      rbank <= 1'b0;
      active <= 1'b0;
      rvalid <= 1'b0;
      ridx <= '0;
      do_en <= 1'b0;
      do_re <= '0;
      do_im <= '0;
      do_idx <= '0;
    end else begin
      if (we) wcnt <= wcnt + 1'b1;
      if (wlast) wbank <= ~wbank;
      if (rd_issue) rcnt <= rcnt + 1'b1;
      if (rlast) rbank <= ~rbank;
      active <= rd_issue && !rlast;
      full <= (full | (2'(wlast) << wbank)) & ~(2'(rlast) << rbank);
      rvalid <= rd_issue;
      ridx <= rcnt;
      do_en <= rvalid;
      if (rvalid) begin
        {do_re, do_im} <= rdata;
        do_idx <= ridx;
      end
    end
  end
  overrun: assert property (@(posedge clock) disable iff (reset) !(di_en && full[wbank]));
  fft_reorder_ram #(.AW(AW + 1), .DW(2 * WIDTH)) ram (
    .clock(clock),
    .we(we),
    .waddr({wbank, wadr}),
    .wdata({di_re, di_im}),
    .re(rd_issue),
    .raddr({rbank, rcnt}),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: frame-level reference model with per-cycle compare plus literal spot checks
module tb_fft_reorder;
  localparam int N = 128;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  logic di_en = 0;
  logic [15:0] di_re = 0, di_im = 0;
  logic do_en;
  logic [15:0] do_re, do_im;
  logic [6:0] do_idx;
  logic di_en8 = 0;
  logic [15:0] di_re8 = 0, di_im8 = 0;
  logic do_en8;
  logic [15:0] do_re8, do_im8;
  logic [2:0] do_idx8;
  fft_reorder #(.N(N), .WIDTH(16)) dut (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx));
  fft_reorder #(.N(8), .WIDTH(16)) dut8 (
    .clock(clock), .reset(reset), .di_en(di_en8), .di_re(di_re8), .di_im(di_im8),
    .do_en(do_en8), .do_re(do_re8), .do_im(do_im8), .do_idx(do_idx8));
  int errs = 0, checks = 0, cyc = 0;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic int brev(int v, int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if ((v & (1 << i)) != 0) r |= 1 << (bits - 1 - i);
    return r;
  endfunction
  // Model: collect a whole frame, then schedule natural bin i at cycle (last input + 2 + i).
  typedef struct {int due; logic [15:0] re; logic [15:0] im; int idx;} exp_t;
  exp_t q[$];
  logic [15:0] fr_re[N], fr_im[N];
  int wk = 0, last_in = 0;
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      wk = 0;
      q.delete();
    end else if (di_en) begin
      fr_re[wk] = di_re;
      fr_im[wk] = di_im;
      wk++;
      if (wk == N) begin
        for (int i = 0; i < N; i++) q.push_back('{cyc + 2 + i, fr_re[brev(i, 7)], fr_im[brev(i, 7)], i});
        wk = 0;
        last_in = cyc;
      end
    end
  end
  logic [15:0] cap_re[N], cap_im[N], last_re = 0, last_im = 0;
  int en_cnt = 0, run = 0, max_run = 0, first_cyc = -1;
  logic [15:0] seq8[$];
  always @(negedge clock) begin
    if (do_en) begin
      cap_re[do_idx] = do_re;
      cap_im[do_idx] = do_im;
      if (en_cnt == 0) first_cyc = cyc;
      en_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (do_en8) seq8.push_back(do_re8);
    if (reset) begin
      check("reset do_en", 32'(do_en), 0);
      check("reset do_re", 32'(do_re), 0);
      check("reset do_im", 32'(do_im), 0);
      check("reset do_idx", 32'(do_idx), 0);
      last_re = 0;
      last_im = 0;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      check("do_en", 32'(do_en), 1);
      check("do_re", 32'(do_re), 32'(q[0].re));
      check("do_im", 32'(do_im), 32'(q[0].im));
      check("do_idx", 32'(do_idx), 32'(q[0].idx));
      last_re = q[0].re;
      last_im = q[0].im;
      void'(q.pop_front());
    end else begin
      check("idle do_en", 32'(do_en), 0);
      check("hold do_re", 32'(do_re), 32'(last_re));
      check("hold do_im", 32'(do_im), 32'(last_im));
    end
  end
  task automatic drive(logic en, logic [15:0] re, logic [15:0] im);
    di_en = en;
    di_re = re;
    di_im = im;
    @(posedge clock);
    #3;
  endtask
  task automatic idle(int n);
    repeat (n) drive(0, 0, 0);
  endtask
  task automatic send(int off, int gap_pct, bit rnd, int cnt);
    for (int k = 0; k < cnt; k++) begin
      while (int'($urandom_range(99)) < gap_pct) drive(0, 0, 0);
      if (rnd) drive(1, 16'($urandom), 16'($urandom));
      else drive(1, 16'(off + k), 16'(16'hFFFF - (off + k)));
    end
  endtask
  task automatic clear_stats();
    en_cnt = 0;
    max_run = 0;
    first_cyc = -1;
  endtask
  initial begin
    int nz;
    logic [15:0] exp8[8];
    exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
    @(posedge clock);
    #3;
    idle(3);
    reset = 0;
    idle(2);
    clear_stats();
    send(0, 0, 0, N);
    idle(N + 10);
    check("t1 idx0 re", 32'(cap_re[0]), 32'h0000);
    check("t1 idx1 re", 32'(cap_re[1]), 32'h0040);
    check("t1 idx2 re", 32'(cap_re[2]), 32'h0020);
    check("t1 idx127 re", 32'(cap_re[127]), 32'h007F);
    check("t1 idx127 im", 32'(cap_im[127]), 32'hFF80);
    check("t1 en count", 32'(en_cnt), 128);
    check("t1 latency", 32'(first_cyc), 32'(last_in + 2));
    clear_stats();
    for (int k = 0; k < N; k++) drive(1, k == 0 ? 16'h7FFF : 16'h0000, 0);
    idle(N + 10);
    check("impulse idx0", 32'(cap_re[0]), 32'h7FFF);
    nz = 0;
    for (int i = 1; i < N; i++) if (cap_re[i] != 0 || cap_im[i] != 0) nz++;
    check("impulse nonzero bins", 32'(nz), 0);
    clear_stats();
    send(16'h0000, 0, 0, N);
    send(16'h1000, 0, 0, N);
    send(16'h2000, 0, 0, N);
    idle(N + 10);
    check("b2b run", 32'(max_run), 384);
    check("b2b frame3 idx1", 32'(cap_re[1]), 32'h2040);
    clear_stats();
    send(0, 50, 0, N);
    idle(N + 10);
    check("gaps en count", 32'(en_cnt), 128);
    check("gaps run", 32'(max_run), 128);
    check("gaps idx1", 32'(cap_re[1]), 32'h0040);
    for (int f = 0; f < 4; f++) send(0, 25, 1, N);
    idle(N + 10);
    clear_stats();
    send(0, 0, 0, 60);
    reset = 1;
    idle(3);
    reset = 0;
    idle(2);
    send(16'h3000, 0, 0, N);
    idle(N + 10);
    check("rst en count", 32'(en_cnt), 128);
    check("rst frame2 idx2", 32'(cap_re[2]), 32'h3020);
    seq8.delete();
    for (int k = 0; k < 8; k++) begin
      di_en8 = 1;
      di_re8 = 16'(k);
      di_im8 = 0;
      @(posedge clock);
      #3;
    end
    di_en8 = 0;
    idle(12);
    check("n8 count", 32'(seq8.size()), 8);
    for (int i = 0; i < 8; i++) check("n8 re", i < seq8.size() ? 32'(seq8[i]) : 32'hFFFF_FFFF, 32'(exp8[i]));
    check("final queue empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
